// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Round-robin arbiter sharing one single-port data memory between three
// masters (0 = load-data fetcher, 1 = store writer, 2 = host/GPIO loader).
// One master holds the grant at a time. A held LOCK keeps the grant for a
// burst, up to MAX_BURST accesses, after which the grant is forcibly released.
// The owner's address/write data are muxed onto the memory. Read data comes
// back one cycle later and is tagged to the port that issued the read.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   req_i[2:0]   per-port request
//   lock_i[2:0]  per-port burst hold (keep grant after an access)
//   we_i[2:0]    per-port write enable, sampled with the request
//   addr_i       per-port word address, port i at [i*ADDR_W +: ADDR_W]
//   wdata_i      per-port write data, port i at [i*DATA_W +: DATA_W]
//   gnt_o[2:0]   registered one-hot grant
//   rvalid_o     one-hot read-data valid, one cycle after a read access
//   rdata_o      read data shared by all ports
//   mem_en_o     memory access strobe
//   mem_we_o     memory write strobe
//   mem_addr_o   memory address (0 outside access cycles)
//   mem_wdata_o  memory write data (0 outside access cycles)
//   mem_rdata_i  memory read data, valid one cycle after a read strobe
//   busy_o       a grant is held
//   owner_o      granted port, 2'd3 when idle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [2:0]            req_i,
    input  logic [2:0]            lock_i,
    input  logic [2:0]            we_i,
    input  logic [3*ADDR_W-1:0]   addr_i,
    input  logic [3*DATA_W-1:0]   wdata_i,
    output logic [2:0]            gnt_o,
    output logic [2:0]            rvalid_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  busy_o,
    output logic [1:0]            owner_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [1:0] OWNER_NONE = 2'd3;

    logic [0:0] state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic [2:0] rd_tag_q, rd_tag_d;

    // Per-port views padded to four entries so that indexing by owner_q is
    // always in range; entry 3 (the "no owner" code) reads as all zeros.
    logic [3:0]        req_ext, lock_ext, we_ext, gnt_ext;
    logic [ADDR_W-1:0] port_addr  [4];
    logic [DATA_W-1:0] port_wdata [4];

    assign req_ext  = {1'b0, req_i};
    assign lock_ext = {1'b0, lock_i};
    assign we_ext   = {1'b0, we_i};
    assign gnt_ext  = {1'b0, gnt_q};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_port
            if (gi < 3) begin : g_real
                assign port_addr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
                assign port_wdata[gi] = wdata_i[gi*DATA_W +: DATA_W];
            end else begin : g_none
                assign port_addr[gi]  = '0;
                assign port_wdata[gi] = '0;
            end
        end
    endgenerate

    // An access happens only in the cycle the owner both holds the grant and
    // still requests it.
    logic access;
    assign access = (state_q == ST_BUSY) && gnt_ext[owner_q] && req_ext[owner_q];

    // Round-robin pick: scan last+1, last+2, last+3 (mod 3) so the previous
    // owner is considered last.
    logic       pick_valid;
    logic [1:0] pick;
    always_comb begin
        pick_valid = 1'b0;
        pick       = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (int'(last_q) + k) % 3;
            if (!pick_valid && req_i[c]) begin
                pick_valid = 1'b1;
                pick       = 2'(c);
            end
        end
    end

    logic last_of_burst;
    assign last_of_burst = ({1'b0, bcnt_q} + 9'd1) == 9'(MAX_BURST);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        bcnt_d   = bcnt_q;
        rd_tag_d = 3'b000;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_BUSY;
                    gnt_d   = 3'b001 << pick;
                    owner_d = pick;
                    bcnt_d  = 8'd0;
                end
            end
            default: begin
                if (access) begin
                    bcnt_d = bcnt_q + 8'd1;
                    if (!we_ext[owner_q]) begin
                        rd_tag_d = 3'b001 << owner_q;
                    end
                end
                // Release on withdrawal, on an unlocked access, or when the
                // burst limit is reached regardless of lock.
                if (!access || !lock_ext[owner_q] || last_of_burst) begin
                    state_d = ST_IDLE;
                    gnt_d   = 3'b000;
                    last_d  = owner_q;
                    owner_d = OWNER_NONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 3'b000;
            owner_q  <= OWNER_NONE;
            last_q   <= 2'd2;
            bcnt_q   <= 8'd0;
            rd_tag_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            bcnt_q   <= bcnt_d;
            rd_tag_q <= rd_tag_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign owner_o     = owner_q;
    assign busy_o      = (state_q == ST_BUSY);
    assign rvalid_o    = rd_tag_q;
    assign rdata_o     = mem_rdata_i;
    assign mem_en_o    = access;
    assign mem_we_o    = access && we_ext[owner_q];
    assign mem_addr_o  = access ? port_addr[owner_q]  : '0;
    assign mem_wdata_o = access ? port_wdata[owner_q] : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [2:0]          req, lock, we;
    logic [3*ADDR_W-1:0] addr;
    logic [3*DATA_W-1:0] wdata;
    logic [2:0]          gnt, rvalid;
    logic [DATA_W-1:0]   rdata;
    logic                mem_en, mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata = '0;
    logic                busy;
    logic [1:0]          owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(16)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy), .owner_o(owner)
    );

    // Memory model: read data is a fixed pattern of the address, one cycle late.
    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return 32'hC000_0000 | {15'd0, a};
    endfunction

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= pat(mem_addr);
    end

    // Port addresses: port0 = a|0x10000, port1 = a, port2 = a|0x08000.
    // Port write data: port0 = d|0x1000_0000, port1 = d, port2 = d|0x2000_0000.
    task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req   = r;
        lock  = l;
        we    = w;
        addr  = {a | 17'h08000, a, a | 17'h10000};
        wdata = {d | 32'h2000_0000, d, d | 32'h1000_0000};
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive(3'b000, 3'b000, 3'b000, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0]        req, lock, we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [2:0]        e_gnt;
        logic              e_en, e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        logic [2:0]        e_rv;
        logic              e_busy;
        logic [1:0]        e_own;
        logic [ADDR_W-1:0] e_raddr;
    } vec_t;

    vec_t vecs [19];

    initial begin
        // Rotation with all three requesting, unlocked reads.
        vecs[0]  = '{3'b111, 3'b000, 3'b000, 17'h00010, 32'h0, 3'b000, 1'b0, 1'b0, 17'h00000, 32'h0,        3'b000, 1'b0, 2'd3, 17'h0};
        vecs[1]  = '{3'b111, 3'b000, 3'b000, 17'h00010, 32'h0, 3'b001, 1'b1, 1'b0, 17'h10010, 32'h10000000, 3'b000, 1'b1, 2'd0, 17'h0};
        vecs[2]  = '{3'b111, 3'b000, 3'b000, 17'h00010, 32'h0, 3'b000, 1'b0, 1'b0, 17'h00000, 32'h0,        3'b001, 1'b0, 2'd3, 17'h10010};
        vecs[3]  = '{3'b111, 3'b000, 3'b000, 17'h00010, 32'h0, 3'b010, 1'b1, 1'b0, 17'h00010, 32'h0,        3'b000, 1'b1, 2'd1, 17'h0};
        vecs[4]  = '{3'b111, 3'b000, 3'b000, 17'h00010, 32'h0, 3'b000, 1'b0, 1'b0, 17'h00000, 32'h0,        3'b010, 1'b0, 2'd3, 17'h00010};
        vecs[5]  = '{3'b111, 3'b000, 3'b000, 17'h00010, 32'h0, 3'b100, 1'b1, 1'b0, 17'h08010, 32'h20000000, 3'b000, 1'b1, 2'd2, 17'h0};
        vecs[6]  = '{3'b111, 3'b000, 3'b000, 17'h00010, 32'h0, 3'b000, 1'b0, 1'b0, 17'h00000, 32'h0,        3'b100, 1'b0, 2'd3, 17'h08010};
        vecs[7]  = '{3'b111, 3'b000, 3'b000, 17'h00010, 32'h0, 3'b001, 1'b1, 1'b0, 17'h10010, 32'h10000000, 3'b000, 1'b1, 2'd0, 17'h0};
        vecs[8]  = '{3'b000, 3'b000, 3'b000, 17'h00010, 32'h0, 3'b000, 1'b0, 1'b0, 17'h00000, 32'h0,        3'b001, 1'b0, 2'd3, 17'h10010};
        // Port 1 locked write burst of four, then release on request drop.
        vecs[9]  = '{3'b010, 3'b010, 3'b010, 17'h00100, 32'hA0, 3'b000, 1'b0, 1'b0, 17'h00000, 32'h0,  3'b000, 1'b0, 2'd3, 17'h0};
        vecs[10] = '{3'b010, 3'b010, 3'b010, 17'h00100, 32'hA0, 3'b010, 1'b1, 1'b1, 17'h00100, 32'hA0, 3'b000, 1'b1, 2'd1, 17'h0};
        vecs[11] = '{3'b010, 3'b010, 3'b010, 17'h00101, 32'hA1, 3'b010, 1'b1, 1'b1, 17'h00101, 32'hA1, 3'b000, 1'b1, 2'd1, 17'h0};
        vecs[12] = '{3'b010, 3'b010, 3'b010, 17'h00102, 32'hA2, 3'b010, 1'b1, 1'b1, 17'h00102, 32'hA2, 3'b000, 1'b1, 2'd1, 17'h0};
        vecs[13] = '{3'b010, 3'b010, 3'b010, 17'h00103, 32'hA3, 3'b010, 1'b1, 1'b1, 17'h00103, 32'hA3, 3'b000, 1'b1, 2'd1, 17'h0};
        vecs[14] = '{3'b000, 3'b000, 3'b000, 17'h00000, 32'h0,  3'b010, 1'b0, 1'b0, 17'h00000, 32'h0,  3'b000, 1'b1, 2'd1, 17'h0};
        vecs[15] = '{3'b000, 3'b000, 3'b000, 17'h00000, 32'h0,  3'b000, 1'b0, 1'b0, 17'h00000, 32'h0,  3'b000, 1'b0, 2'd3, 17'h0};
        // Port 2 granted, withdraws before its access.
        vecs[16] = '{3'b100, 3'b000, 3'b000, 17'h00055, 32'h0,  3'b000, 1'b0, 1'b0, 17'h00000, 32'h0,  3'b000, 1'b0, 2'd3, 17'h0};
        vecs[17] = '{3'b000, 3'b000, 3'b000, 17'h00055, 32'h0,  3'b100, 1'b0, 1'b0, 17'h00000, 32'h0,  3'b000, 1'b1, 2'd2, 17'h0};
        vecs[18] = '{3'b000, 3'b000, 3'b000, 17'h00055, 32'h0,  3'b000, 1'b0, 1'b0, 17'h00000, 32'h0,  3'b000, 1'b0, 2'd3, 17'h0};

        // Reset state.
        reset_dut();
        @(negedge clk);
        check("rst_gnt",    64'(gnt), 64'h0);
        check("rst_rvalid", 64'(rvalid), 64'h0);
        check("rst_busy",   64'(busy), 64'h0);
        check("rst_owner",  64'(owner), 64'h3);
        check("rst_en_we",  64'({mem_en, mem_we}), 64'h0);
        check("rst_addr",   64'(mem_addr), 64'h0);
        check("rst_wdata",  64'(mem_wdata), 64'h0);

        // Table-driven vectors, one per cycle.
        for (int i = 0; i < 19; i++) begin
            next_cycle();
            drive(vecs[i].req, vecs[i].lock, vecs[i].we, vecs[i].a, vecs[i].d);
            @(negedge clk);
            $display("vec %0d: req=%b gnt=%b en=%b we=%b addr=%h rv=%b owner=%0d",
                     i, req, gnt, mem_en, mem_we, mem_addr, rvalid, owner);
            check($sformatf("v%0d_gnt", i),    64'(gnt),       64'(vecs[i].e_gnt));
            check($sformatf("v%0d_en", i),     64'(mem_en),    64'(vecs[i].e_en));
            check($sformatf("v%0d_we", i),     64'(mem_we),    64'(vecs[i].e_we));
            check($sformatf("v%0d_addr", i),   64'(mem_addr),  64'(vecs[i].e_addr));
            check($sformatf("v%0d_wdata", i),  64'(mem_wdata), 64'(vecs[i].e_wd));
            check($sformatf("v%0d_rvalid", i), 64'(rvalid),    64'(vecs[i].e_rv));
            check($sformatf("v%0d_busy", i),   64'(busy),      64'(vecs[i].e_busy));
            check($sformatf("v%0d_owner", i),  64'(owner),     64'(vecs[i].e_own));
            if (vecs[i].e_rv != 3'b000)
                check($sformatf("v%0d_rdata", i), 64'(rdata), 64'(pat(vecs[i].e_raddr)));
        end

        // Locked read stream on port 0 with port 2 also requesting:
        // forced release after 16 accesses.
        reset_dut();
        drive(3'b101, 3'b001, 3'b000, 17'd0, 32'd0);
        @(negedge clk);
        check("burst_idle_gnt", 64'(gnt), 64'h0);
        for (int k = 0; k < 16; k++) begin
            next_cycle();
            drive(3'b101, 3'b001, 3'b000, 17'(k), 32'd0);
            @(negedge clk);
            $display("burst %0d: gnt=%b en=%b addr=%h rv=%b", k, gnt, mem_en, mem_addr, rvalid);
            check($sformatf("burst%0d_gnt", k),  64'(gnt), 64'h1);
            check($sformatf("burst%0d_en", k),   64'(mem_en), 64'h1);
            check($sformatf("burst%0d_addr", k), 64'(mem_addr), 64'(17'h10000 | 17'(k)));
            if (k > 0) begin
                check($sformatf("burst%0d_rvalid", k), 64'(rvalid), 64'h1);
                check($sformatf("burst%0d_rdata", k),  64'(rdata), 64'(pat(17'h10000 | 17'(k - 1))));
            end else begin
                check("burst0_rvalid", 64'(rvalid), 64'h0);
            end
        end
        next_cycle();
        drive(3'b101, 3'b001, 3'b000, 17'd16, 32'd0);
        @(negedge clk);
        check("forced_rel_gnt",    64'(gnt), 64'h0);
        check("forced_rel_en",     64'(mem_en), 64'h0);
        check("forced_rel_busy",   64'(busy), 64'h0);
        check("forced_rel_rvalid", 64'(rvalid), 64'h1);
        check("forced_rel_rdata",  64'(rdata), 64'(pat(17'h1000F)));
        next_cycle();
        @(negedge clk);
        check("p2_gnt",    64'(gnt), 64'h4);
        check("p2_addr",   64'(mem_addr), 64'(17'h08010));
        check("p2_rvalid", 64'(rvalid), 64'h0);
        next_cycle();
        @(negedge clk);
        check("p2_rel_gnt",   64'(gnt), 64'h0);
        check("p2_rel_rvalid", 64'(rvalid), 64'h4);
        check("p2_rel_rdata", 64'(rdata), 64'(pat(17'h08010)));
        next_cycle();
        @(negedge clk);
        check("p0_regain_gnt",  64'(gnt), 64'h1);
        check("p0_regain_addr", 64'(mem_addr), 64'(17'h10010));
        next_cycle();
        drive(3'b000, 3'b000, 3'b000, '0, '0);

        // Reset asserted mid locked burst, one cycle after a read access.
        reset_dut();
        drive(3'b001, 3'b001, 3'b000, 17'h00007, 32'd0);
        @(negedge clk);
        check("mid_idle_gnt", 64'(gnt), 64'h0);
        next_cycle();
        @(negedge clk);
        check("mid_access_en", 64'(mem_en), 64'h1);
        next_cycle();
        @(negedge clk);
        check("mid_pre_rvalid", 64'(rvalid), 64'h1);
        check("mid_pre_busy",   64'(busy), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_gnt",    64'(gnt), 64'h0);
        check("mid_rst_rvalid", 64'(rvalid), 64'h0);
        check("mid_rst_busy",   64'(busy), 64'h0);
        check("mid_rst_owner",  64'(owner), 64'h3);
        next_cycle();
        rst = 1'b0;
        drive(3'b111, 3'b000, 3'b000, 17'h00020, 32'd0);
        @(negedge clk);
        check("post_rst_idle_gnt", 64'(gnt), 64'h0);
        next_cycle();
        @(negedge clk);
        check("post_rst_first_gnt", 64'(gnt), 64'h1);
        check("post_rst_owner",     64'(owner), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter sharing the single-port data memory between three masters: port 0 = load-data fetcher (LOADA/LOADB), port 1 = store writer (STORE), port 2 = host/GPIO program-and-data loader. It grants one master at a time and supports locked bursts with a forced-release limit. It muxes address and write data onto the memory and routes 1-cycle-latency read data back to the issuing port.

## Interface
- ADDR_W, 17, memory word address width
- DATA_W, 32, memory data width
- MAX_BURST, 16, maximum accesses per grant before forced release; legal range 1..255
- CLK  in  1  clock, rising edge
- RSTN  in  1  reset, asynchronous, active-high
- REQ  in  3  per-port request; bit i = port i
- LOCK  in  3  per-port burst hold; keep grant after an access
- WE  in  3  per-port write enable, sampled with REQ
- ADDR  in  3*ADDR_W  per-port address; port i at [i*ADDR_W +: ADDR_W]
- WDATA  in  3*DATA_W  per-port write data, same packing
- GNT  out  3  registered one-hot grant
- RVALID  out  3  one-hot read-data valid
- RDATA  out  DATA_W  read data, shared by all ports
- MEM_EN  out  1  memory access strobe
- MEM_WE  out  1  memory write strobe
- MEM_ADDR  out  ADDR_W  memory address
- MEM_WDATA  out  DATA_W  memory write data
- MEM_RDATA  in  DATA_W  memory read data, valid 1 cycle after a read strobe
- BUSY  out  1  a grant is held
- OWNER  out  2  granted port; 2'd3 when idle

## Operation
- Registers: STATE {IDLE, BUSY}, OWNER, LAST (last owner), BCNT (8-bit burst count), RD_TAG (3-bit one-hot pending read).
- IDLE: if REQ != 0, pick the first requesting port scanning LAST+1, LAST+2, LAST+3 (mod 3). Register GNT, OWNER; BCNT <= 0; go BUSY.
- BUSY, access cycle = GNT[OWNER] & REQ[OWNER]:
  - MEM_EN = 1, MEM_WE = WE[OWNER], MEM_ADDR/MEM_WDATA = ADDR/WDATA slice of OWNER; combinational from the registered grant.
  - BCNT <= BCNT+1.
  - Read access: RD_TAG <= one-hot(OWNER).
- BUSY release (go IDLE, GNT <= 0, LAST <= OWNER, OWNER <= 3) when any of:
  - REQ[OWNER] = 0 (owner withdrew; no access).
  - Access with LOCK[OWNER] = 0: single access per grant.
  - Access with BCNT+1 == MAX_BURST, regardless of LOCK.
- Otherwise stay BUSY, keep grant.
- Non-owner ports: no memory side effects. MEM_EN = 0 outside access cycles; MEM_ADDR/MEM_WDATA = 0 then.
- Read return: RVALID = RD_TAG, RDATA = MEM_RDATA, one cycle after the read access. This holds even if the grant was released in between. RD_TAG clears to 0 on any cycle without a read access.
- Write accesses never assert RVALID.

## Timing
- Reset (async assert, sync deassert): STATE = IDLE, GNT = 0, OWNER = 3, LAST = 2 (port 0 wins first), BCNT = 0, RD_TAG = 0. Outputs: RVALID = 0, BUSY = 0, MEM_EN = 0, MEM_WE = 0, MEM_ADDR = 0, MEM_WDATA = 0, RDATA = MEM_RDATA (don't-care while RVALID = 0).
- Reset mid-burst: grant and pending RVALID are dropped immediately; the read is lost.
- Latency REQ -> GNT: 1 cycle from IDLE. First access occurs in the cycle GNT is high.
- Unlocked throughput: 1 access per 2 cycles (access, IDLE re-arbitrate). Locked: 1 access/cycle up to MAX_BURST.
- Masters hold REQ/WE/ADDR/WDATA stable until they see GNT. A master must not deassert LOCK and expect a further access in the same grant.
- The released owner is lowest priority in the next IDLE cycle. With all three requesting, grants rotate 0,1,2,0…
- MAX_BURST = 1: every grant is a single access, same as LOCK = 0.
- BUSY = (STATE == BUSY).

## Test plan
- Reset, REQ=3'b111, LOCK=0, all reads: GNT sequence 001,0,010,0,100,0,001; one MEM_EN per grant; RVALID one-hot matches the port one cycle after each access.
- Port 1, LOCK=1, WE=1, 4 writes, addr 0x100..0x103, data 0xA0..0xA3: GNT=010 for 4 access cycles. MEM_WE=1, addresses/data in order; then release on REQ drop, BUSY=0 one cycle after.
- MAX_BURST=16, port 0 locked read stream of 20 while port 2 requests: port 0 gets exactly 16 accesses, then GNT=100. Port 0 regains the grant after port 2 releases.
- Read at last burst access (forced release): RVALID[owner]=1 with MEM_RDATA in the cycle after, while GNT=0.
- Port 2 grant, REQ[2] dropped before access: MEM_EN stays 0, release next cycle, no RVALID.
- Assert RSTN mid-locked-burst, one cycle after a read access: GNT, RVALID, BUSY go 0 immediately; OWNER=3. After deassert, port 0 wins the first arbitration.
